// File: rtl/wb_slave_ram_if.sv
// Wishbone classic-cycle link between an intercon (master side) and a RAM slave.
// dat_w/tgd_w flow master->slave, dat_r/tgd_r flow slave->master.
interface wb_slave_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [ADDR_WIDTH-1:0]     adr;
    logic [DATA_WIDTH/8-1:0]   sel;
    logic [DATA_WIDTH-1:0]     dat_w;
    logic                      tga;
    logic                      tgc;
    logic                      tgd_w;
    logic [DATA_WIDTH-1:0]     dat_r;
    logic                      tgd_r;
    logic                      ack;
    logic                      err;
    logic                      rty;

    modport master (
        output cyc, stb, we, adr, sel, dat_w, tga, tgc, tgd_w,
        input  dat_r, tgd_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w, tga, tgc, tgd_w,
        output dat_r, tgd_r, ack, err, rty
    );
endinterface

// File: rtl/wb_slave_ram.sv
// Wishbone classic slave RAM: byte-lane writes, programmable wait states and
// registered ACK/ERR/RTY terminations.
module wb_slave_ram #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          busy_i,
    wb_slave_ram_if.slave bus
);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(SEL_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0]            WS_CNT     = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(SEL_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [SEL_W-1:0]        sel_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic                    ack_q;
    logic                    err_q;
    logic                    rty_q;
    logic [DATA_WIDTH-1:0]   rdat_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    reqValid;
    logic                    reqWe;
    logic [ADDR_WIDTH-1:0]   reqAdr;
    logic [SEL_W-1:0]        reqSel;
    logic [DATA_WIDTH-1:0]   reqDat;
    logic [ADDR_WIDTH:0]     diff;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        wordIdx;
    logic                    enterTerm;
    logic                    err_d;
    logic                    rty_d;
    logic                    ack_d;
    logic                    doWrite;
    logic                    unusedTags;

    assign reqValid = bus.cyc && bus.stb;

    // With zero wait states the request goes straight to TERM, so decode the live bus.
    assign reqWe  = (state_q == S_IDLE) ? bus.we    : we_q;
    assign reqAdr = (state_q == S_IDLE) ? bus.adr   : adr_q;
    assign reqSel = (state_q == S_IDLE) ? bus.sel   : sel_q;
    assign reqDat = (state_q == S_IDLE) ? bus.dat_w : dat_q;

    // The extra borrow bit flags addresses below the base without relying on wrap-around.
    assign diff    = {1'b0, reqAdr} - {1'b0, BASE_ADDR};
    assign offset  = diff[ADDR_WIDTH-1:0];
    assign wordIdx = offset[LSB +: IDX_W];

    assign enterTerm = (state_q == S_IDLE && reqValid && WS_CNT == 4'd0) ||
                       (state_q == S_WAIT && reqValid && cnt_q == 4'd1);

    assign err_d = diff[ADDR_WIDTH] ||
                   ((offset >> (LSB + IDX_W)) != '0) ||
                   ((offset & ALIGN_MASK) != '0);
    assign rty_d = !err_d && busy_i;
    assign ack_d = !err_d && !busy_i;

    assign doWrite = rst_n_i && enterTerm && ack_d && reqWe;

    assign unusedTags = ^{bus.tga, bus.tgc, bus.tgd_w};

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rty   = rty_q;
    assign bus.dat_r = rdat_q;
    assign bus.tgd_r = 1'b0;

    // Storage is never cleared by reset.
    always_ff @(posedge clk_i) begin
        if (doWrite) begin
            for (int k = 0; k < SEL_W; k++) begin
                if (reqSel[k]) begin
                    mem_q[wordIdx][8*k +: 8] <= reqDat[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rty_q  <= 1'b0;
            rdat_q <= '0;
            if (enterTerm) begin
                ack_q <= ack_d;
                err_q <= err_d;
                rty_q <= rty_d;
                if (ack_d && !reqWe) begin
                    rdat_q <= mem_q[wordIdx];
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (reqValid) begin
                        we_q    <= bus.we;
                        adr_q   <= bus.adr;
                        sel_q   <= bus.sel;
                        dat_q   <= bus.dat_w;
                        cnt_q   <= WS_CNT;
                        state_q <= (WS_CNT == 4'd0) ? S_TERM : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!reqValid) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= S_TERM;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_TERM: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed bench for wb_slave_ram: one slave with 1 wait state, one with 3,
// sharing a single request driver selected by 'target'.
module tb_wb_slave_ram;
    logic        clk = 1'b0;
    logic        rstN;
    logic        busy;
    logic        target;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] datW;
    logic        ack;
    logic        err;
    logic        rty;
    logic [31:0] datR;
    int          testsRun = 0;
    int          testsFailed = 0;

    wb_slave_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) busFast ();
    wb_slave_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) busSlow ();

    wb_slave_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(1)
    ) dutFast (
        .clk_i(clk), .rst_n_i(rstN), .busy_i(busy), .bus(busFast.slave)
    );

    wb_slave_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(3)
    ) dutSlow (
        .clk_i(clk), .rst_n_i(rstN), .busy_i(busy), .bus(busSlow.slave)
    );

    assign busFast.cyc   = cyc & ~target;
    assign busFast.stb   = stb & ~target;
    assign busFast.we    = we;
    assign busFast.adr   = adr;
    assign busFast.sel   = sel;
    assign busFast.dat_w = datW;
    assign busFast.tga   = 1'b0;
    assign busFast.tgc   = 1'b0;
    assign busFast.tgd_w = 1'b0;
    assign busSlow.cyc   = cyc & target;
    assign busSlow.stb   = stb & target;
    assign busSlow.we    = we;
    assign busSlow.adr   = adr;
    assign busSlow.sel   = sel;
    assign busSlow.dat_w = datW;
    assign busSlow.tga   = 1'b0;
    assign busSlow.tgc   = 1'b0;
    assign busSlow.tgd_w = 1'b0;

    assign ack  = target ? busSlow.ack   : busFast.ack;
    assign err  = target ? busSlow.err   : busFast.err;
    assign rty  = target ? busSlow.rty   : busFast.rty;
    assign datR = target ? busSlow.dat_r : busFast.dat_r;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // expTerm is {ack, err, rty}; write-ack data is not checked.
    task automatic applyStimulus(input string tag, input logic isWrite, input logic [31:0] a,
                                 input logic [3:0] s, input logic [31:0] d, input logic isBusy,
                                 input int expLat, input logic [2:0] expTerm, input logic [31:0] expData);
        int          lat;
        logic        seen;
        logic [2:0]  term;
        logic [31:0] data;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = isWrite; adr = a; sel = s; datW = d; busy = isBusy;
        lat = 0; seen = 1'b0; term = 3'b000; data = 32'h0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (ack || err || rty) begin
                seen = 1'b1;
                term = {ack, err, rty};
                data = datR;
            end
        end
        cyc = 1'b0; stb = 1'b0; busy = 1'b0;
        checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_lat"}, lat, expLat);
        checkOutput({tag, "_term"}, 32'(term), 32'(expTerm));
        if (!(isWrite && expTerm == 3'b100)) begin
            checkOutput({tag, "_data"}, data, expData);
        end
        @(posedge clk); #1;
        checkOutput({tag, "_pulse"}, 32'({ack, err, rty}), 32'd0);
    endtask

    initial begin
        logic anyTerm;
        int   ackCount;
        int   cycleN;
        int   ackAt [3];

        rstN = 1'b0; busy = 1'b0; target = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; sel = 4'h0; datW = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_fast_term", 32'({ack, err, rty}), 32'd0);
        checkOutput("rst_fast_dat", datR, 32'h0);
        checkOutput("rst_fast_tgd", 32'(busFast.tgd_r), 32'd0);
        target = 1'b1;
        #1;
        checkOutput("rst_slow_term", 32'({ack, err, rty}), 32'd0);
        checkOutput("rst_slow_dat", datR, 32'h0);
        @(negedge clk);
        rstN = 1'b1; target = 1'b0;

        // Basic write/read with one wait state
        applyStimulus("t1_wr", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 2, 3'b100, 32'h0);
        applyStimulus("t1_rd", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 2, 3'b100, 32'hDEADBEEF);
        applyStimulus("t2_wr", 1'b1, 32'h10, 4'b0001, 32'h000000AA, 1'b0, 2, 3'b100, 32'h0);
        applyStimulus("t2_rd", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 2, 3'b100, 32'hDEADBEAA);

        // Address decode boundaries: last word, one past the end, misaligned
        applyStimulus("last_wr", 1'b1, 32'h3FC, 4'hF, 32'h12345678, 1'b0, 2, 3'b100, 32'h0);
        applyStimulus("last_rd", 1'b0, 32'h3FC, 4'hF, 32'h0, 1'b0, 2, 3'b100, 32'h12345678);
        applyStimulus("t3_oor", 1'b0, 32'h400, 4'hF, 32'h0, 1'b0, 2, 3'b010, 32'h0);
        applyStimulus("t3_mis", 1'b0, 32'h11, 4'hF, 32'h0, 1'b0, 2, 3'b010, 32'h0);
        applyStimulus("err_wr", 1'b1, 32'h13, 4'hF, 32'hFFFFFFFF, 1'b0, 2, 3'b010, 32'h0);
        applyStimulus("err_rd", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 2, 3'b100, 32'hDEADBEAA);

        // Retry leaves memory untouched; empty byte enables are a harmless ack
        applyStimulus("t4_init", 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, 2, 3'b100, 32'h0);
        applyStimulus("t4_busy", 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF, 1'b1, 2, 3'b001, 32'h0);
        applyStimulus("t4_rd", 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 2, 3'b100, 32'h11223344);
        applyStimulus("sel0_wr", 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 2, 3'b100, 32'h0);
        applyStimulus("sel0_rd", 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 2, 3'b100, 32'h11223344);
        applyStimulus("rtyrd", 1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 2, 3'b001, 32'h0);

        // Three wait states, including an aborted write
        @(negedge clk);
        target = 1'b1;
        applyStimulus("t5_wr", 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 1'b0, 4, 3'b100, 32'h0);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h30; sel = 4'hF; datW = 32'h0;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        anyTerm = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack || err || rty) anyTerm = 1'b1;
        end
        checkOutput("t5_abort_noterm", 32'(anyTerm), 32'd0);
        applyStimulus("t5_rd", 1'b0, 32'h30, 4'hF, 32'h0, 1'b0, 4, 3'b100, 32'hCAFEF00D);

        // Reset on the cycle that would otherwise commit a write
        @(negedge clk);
        target = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; sel = 4'hF; datW = 32'h55555555;
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk); #1;
        checkOutput("t6_rst_term", 32'({ack, err, rty}), 32'd0);
        checkOutput("t6_rst_dat", datR, 32'h0);
        @(negedge clk);
        rstN = 1'b1; cyc = 1'b0; stb = 1'b0;
        applyStimulus("t6_rd", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 2, 3'b100, 32'hDEADBEAA);

        // Held strobe: one ack per transfer, spaced WAIT_STATES+2 cycles
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF;
        ackCount = 0; cycleN = 0;
        for (int i = 0; i < 3; i++) ackAt[i] = 0;
        while (ackCount < 3 && cycleN < 40) begin
            @(posedge clk); #1;
            cycleN++;
            if (ack) begin
                ackAt[ackCount] = cycleN;
                ackCount++;
                checkOutput("held_data", datR, 32'hDEADBEAA);
            end
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack) ackCount++;
        end
        checkOutput("held_count", ackCount, 32'd3);
        checkOutput("held_ack0", ackAt[0], 32'd2);
        checkOutput("held_ack1", ackAt[1], 32'd5);
        checkOutput("held_ack2", ackAt[2], 32'd8);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
